// File: rtl/bus_slave_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bus_slave_ram : word-addressed RAM slave with programmable wait FSM  |
// | Optional BUS_SLAVE_RANGE_CHK_EN adds Err for out-of-range addresses. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module bus_slave_ram #(
  parameter int ADDR_W      = 30,
  parameter int DATA_W      = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Cs_,
  input  logic              As_,
  input  logic              RW,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] WrData,
  output logic [DATA_W-1:0] RdData,
  output logic              Rdy_
`ifdef BUS_SLAVE_RANGE_CHK_EN
  ,
  output logic              Err
`endif
);

  localparam int DEPTH       = 1 << DEPTH_LOG2;
  localparam int WAIT_INIT_I = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_INIT_I);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q;
  logic                rw_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                w_req;
  logic                w_enter_ack;
  logic [ADDR_W-1:0]   w_xfer_addr;
  logic                w_xfer_rw;
  logic [DATA_W-1:0]   w_xfer_wdata;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                w_oor;
  logic                w_wr_en;

  assign w_req = ~Cs_ & ~As_;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    w_enter_ack = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_req) begin
          if (WAIT_CYCLES == 0) begin
            state_d     = S_ACK;
            w_enter_ack = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        // Master dropping the strobe or select abandons the transfer.
        if (Cs_ || As_) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d     = S_ACK;
          w_enter_ack = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // With zero wait states the commit edge is the accept edge, so use live inputs.
  assign w_xfer_addr  = (state_q == S_IDLE) ? Addr   : addr_q;
  assign w_xfer_rw    = (state_q == S_IDLE) ? RW     : rw_q;
  assign w_xfer_wdata = (state_q == S_IDLE) ? WrData : wdata_q;
  assign w_idx        = w_xfer_addr[DEPTH_LOG2-1:0];

`ifdef BUS_SLAVE_RANGE_CHK_EN
  logic err_q;
  assign w_oor = |w_xfer_addr[ADDR_W-1:DEPTH_LOG2];
  assign Err   = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= w_enter_ack & w_oor;
    end
  end
`else
  logic w_unused_upper;
  assign w_unused_upper = |w_xfer_addr[ADDR_W-1:DEPTH_LOG2];
  assign w_oor          = 1'b0;
`endif

  assign w_wr_en = w_enter_ack & ~w_xfer_rw & ~w_oor & ~reset;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      mem_q[w_idx] <= w_xfer_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if ((state_q == S_IDLE) && w_req) begin
        addr_q  <= Addr;
        rw_q    <= RW;
        wdata_q <= WrData;
      end
      // Only non-zero during the ACK cycle of an in-range read.
      rdata_q <= (w_enter_ack && w_xfer_rw && !w_oor) ? mem_q[w_idx] : '0;
    end
  end

  assign RdData = rdata_q;
  assign Rdy_   = (state_q != S_ACK);

endmodule
`default_nettype wire

// File: tb/tb_bus_slave_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bus_slave_ram : checks two slaves (2 and 0 wait states) against   |
// | an array model of memory and transfer timing. Rev 1.0                |
// +----------------------------------------------------------------------+
module tb_bus_slave_ram;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs_n   [2];
  logic        as_n   [2];
  logic        rw_s   [2];
  logic [29:0] addr_s [2];
  logic [31:0] wdat_s [2];
  logic [31:0] rdata  [2];
  logic        rdy_n  [2];
`ifdef BUS_SLAVE_RANGE_CHK_EN
  logic        err    [2];
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [31:0] mdl  [2][1024];
  bit          mval [2][1024];

  always #5 clk = ~clk;

  bus_slave_ram #(.ADDR_W(30), .DATA_W(32), .DEPTH_LOG2(10), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .reset(reset), .Cs_(cs_n[0]), .As_(as_n[0]), .RW(rw_s[0]),
    .Addr(addr_s[0]), .WrData(wdat_s[0]), .RdData(rdata[0]), .Rdy_(rdy_n[0])
`ifdef BUS_SLAVE_RANGE_CHK_EN
    , .Err(err[0])
`endif
  );

  bus_slave_ram #(.ADDR_W(30), .DATA_W(32), .DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(reset), .Cs_(cs_n[1]), .As_(as_n[1]), .RW(rw_s[1]),
    .Addr(addr_s[1]), .WrData(wdat_s[1]), .RdData(rdata[1]), .Rdy_(rdy_n[1])
`ifdef BUS_SLAVE_RANGE_CHK_EN
    , .Err(err[1])
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input int u, input string tag);
    check({tag, "_rdy"}, {31'd0, rdy_n[u]}, 32'd1);
    check({tag, "_rdata"}, rdata[u], 32'd0);
`ifdef BUS_SLAVE_RANGE_CHK_EN
    check({tag, "_err"}, {31'd0, err[u]}, 32'd0);
`endif
  endtask

  function automatic int wait_of(input int u);
    return (u == 0) ? 2 : 0;
  endfunction

  function automatic bit is_oor(input logic [29:0] a);
    return CHK && (a >= 30'd1024);
  endfunction

  task automatic idle(input int u);
    cs_n[u] = 1'b1; as_n[u] = 1'b1; rw_s[u] = 1'b1;
  endtask

  // One complete transfer; from_ack means the request is raised during the
  // previous ACK cycle, hold leaves the request asserted after this ACK.
  task automatic xfer(input int u, input logic rw, input logic [29:0] a,
                      input logic [31:0] wd, input bit from_ack, input bit hold);
    int          lat;
    int          key;
    logic [31:0] exp_rd;
    bit          oor;
    cs_n[u] = 1'b0; as_n[u] = 1'b0; rw_s[u] = rw; addr_s[u] = a; wdat_s[u] = wd;
    lat = wait_of(u) + 1 + (from_ack ? 1 : 0);
    oor = is_oor(a);
    key = int'(a % 30'd1024);
    for (int k = 1; k <= lat; k++) begin
      tick();
      if (k < lat) check_idle(u, "wait");
    end
    exp_rd = (rw && !oor) ? mdl[u][key] : 32'd0;
    check("ack_rdy", {31'd0, rdy_n[u]}, 32'd0);
    check(rw ? "ack_rdata_rd" : "ack_rdata_wr", rdata[u], exp_rd);
`ifdef BUS_SLAVE_RANGE_CHK_EN
    check("ack_err", {31'd0, err[u]}, {31'd0, oor});
`endif
    if (!rw && !oor) begin
      mdl[u][key]  = wd;
      mval[u][key] = 1'b1;
    end
    if (!hold) begin
      idle(u);
      tick();
      check_idle(u, "post_ack");
    end
  endtask

  initial begin
    logic [29:0] a;
    logic        rw;
    int          u;
    for (int i = 0; i < 2; i++) begin
      idle(i); addr_s[i] = '0; wdat_s[i] = '0;
      for (int j = 0; j < 1024; j++) begin
        mdl[i][j] = 32'd0; mval[i][j] = 1'b0;
      end
    end
    reset = 1'b1;
    tick(); tick();
    check_idle(0, "reset_w2");
    check_idle(1, "reset_w0");
    reset = 1'b0;
    tick();

    // Basic write then read with two wait states.
    xfer(0, 1'b0, 30'h005, 32'hDEADBEEF, 1'b0, 1'b0);
    xfer(0, 1'b1, 30'h005, 32'h0, 1'b0, 1'b0);

    // Zero wait states, top address, then back-to-back reads.
    xfer(1, 1'b0, 30'h3FF, 32'h12345678, 1'b0, 1'b0);
    xfer(1, 1'b1, 30'h3FF, 32'h0, 1'b0, 1'b1);
    xfer(1, 1'b1, 30'h3FF, 32'h0, 1'b1, 1'b1);
    xfer(1, 1'b0, 30'h3FE, 32'hA5A5_0F0F, 1'b1, 1'b1);
    xfer(1, 1'b1, 30'h3FE, 32'h0, 1'b1, 1'b0);

    // Abort during WAIT leaves memory unchanged and never acknowledges.
    xfer(0, 1'b0, 30'h010, 32'h0, 1'b0, 1'b0);
    cs_n[0] = 1'b0; as_n[0] = 1'b0; rw_s[0] = 1'b0; addr_s[0] = 30'h010; wdat_s[0] = 32'hAAAA5555;
    tick(); check_idle(0, "abort_w1");
    tick(); check_idle(0, "abort_w2");
    as_n[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick(); check_idle(0, "abort_after");
    end
    idle(0);
    xfer(0, 1'b1, 30'h010, 32'h0, 1'b0, 1'b0);

    // Reset in the middle of a waited write discards it.
    xfer(0, 1'b0, 30'h020, 32'hCAFEF00D, 1'b0, 1'b0);
    cs_n[0] = 1'b0; as_n[0] = 1'b0; rw_s[0] = 1'b0; addr_s[0] = 30'h020; wdat_s[0] = 32'h11111111;
    tick(); check_idle(0, "rst_mid_wait");
    reset = 1'b1;
    tick();
    reset = 1'b0; idle(0);
    check_idle(0, "rst_after");
    for (int k = 0; k < 3; k++) begin
      tick(); check_idle(0, "rst_idle");
    end
    xfer(0, 1'b1, 30'h020, 32'h0, 1'b0, 1'b0);

    // Another slave selected: strobe alone must do nothing.
    cs_n[0] = 1'b1; as_n[0] = 1'b0; rw_s[0] = 1'b0; addr_s[0] = 30'h005; wdat_s[0] = 32'hFFFFFFFF;
    for (int k = 0; k < 5; k++) begin
      tick(); check_idle(0, "other_slave");
    end
    idle(0);
    tick();
    xfer(0, 1'b1, 30'h005, 32'h0, 1'b0, 1'b0);

    // Upper address bits: error response or aliasing depending on build.
    for (int i = 0; i < 2; i++) begin
      xfer(i, 1'b0, 30'h000, 32'h0000_0077, 1'b0, 1'b0);
      xfer(i, 1'b0, 30'h400, 32'h0000_0001, 1'b0, 1'b0);
      xfer(i, 1'b1, 30'h000, 32'h0, 1'b0, 1'b0);
      xfer(i, 1'b1, 30'h400, 32'h0, 1'b0, 1'b0);
    end

    // Randomized traffic on a small address pool to hit read-after-write.
    for (int n = 0; n < 40; n++) begin
      u  = int'($urandom_range(0, 1));
      a  = 30'h030 + 30'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) a = a | (30'h400 << $urandom_range(0, 6));
      rw = 1'($urandom_range(0, 1));
      if (rw && !is_oor(a) && !mval[u][int'(a % 30'd1024)]) rw = 1'b0;
      xfer(u, rw, a, $urandom, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
